// File: rtl/seg7_capture_if.sv
// Display-bus bundle for seg7_capture: the sampled segment pattern and clear
// from the bus side, and decoded digit / status toward the consumer.
interface seg7_capture_if;
    logic [6:0] seg_in;
    logic       clr;
    logic [3:0] digit;
    logic       digit_valid;
    logic       blank;
    logic       invalid;
    logic [7:0] change_cnt;
    logic       seq_err;

    modport master (
        output seg_in, clr,
        input  digit, digit_valid, blank, invalid, change_cnt, seq_err
    );

    modport slave (
        input  seg_in, clr,
        output digit, digit_valid, blank, invalid, change_cnt, seq_err
    );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: seven-segment receive side. Synchronizes an asynchronous
// segment pattern, qualifies it with a stability window and decodes it back
// to a hex digit, with sticky invalid flag and a saturating change counter.
// Optional sequence check enabled by defining SEG7_CAPTURE_SEQ_CHECK_EN.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MODULO        = 7
) (
    input logic          clk,
    input logic          rst_n,
    seg7_capture_if.slave bus
);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
        $error("seg7_capture: STABLE_CYCLES out of range 2..255");
    end
    if (MODULO < 2 || MODULO > 16) begin : g_bad_modulo
        $error("seg7_capture: MODULO out of range 2..16");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    typedef struct packed {
        logic       ok;
        logic [3:0] digit;
    } dec_t;

    state_t     state, state_nxt;
    logic [6:0] sync1, sync2, cand, cand_nxt, locked;
    logic [7:0] stab, stab_nxt;
    logic       accept;
    dec_t       dec;

    logic [3:0] digit_r;
    logic       digit_valid_r, blank_r, invalid_r;
    logic [7:0] change_cnt_r;

    // Pattern-to-digit lookup for the candidate being qualified.
    always_comb begin
        dec = '{ok: 1'b1, digit: 4'h0};
        case (cand)
            7'h3F: dec.digit = 4'h0;
            7'h06: dec.digit = 4'h1;
            7'h5B: dec.digit = 4'h2;
            7'h4F: dec.digit = 4'h3;
            7'h66: dec.digit = 4'h4;
            7'h6D: dec.digit = 4'h5;
            7'h7D: dec.digit = 4'h6;
            7'h07: dec.digit = 4'h7;
            7'h7F: dec.digit = 4'h8;
            7'h6F: dec.digit = 4'h9;
            7'h77: dec.digit = 4'hA;
            7'h7C: dec.digit = 4'hB;
            7'h39: dec.digit = 4'hC;
            7'h5E: dec.digit = 4'hD;
            7'h79: dec.digit = 4'hE;
            7'h71: dec.digit = 4'hF;
            default: dec.ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Any change of the synchronized pattern restarts the window; a full
    // window in SETTLE produces a single accept.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        stab_nxt  = stab;
        accept    = 1'b0;
        if (sync2 != cand) begin
            cand_nxt  = sync2;
            stab_nxt  = 8'd0;
            state_nxt = SETTLE;
        end else if (state == SETTLE) begin
            if (stab < STAB_LAST) begin
                stab_nxt = stab + 8'd1;
            end else begin
                accept    = 1'b1;
                state_nxt = LOCKED;
            end
        end
    end

    // Input synchronizer, candidate tracking and accept side effects.
    // clr is applied last so it wins over a same-cycle count or invalid set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1         <= 7'h00;
            sync2         <= 7'h00;
            cand          <= 7'h00;
            stab          <= 8'd0;
            locked        <= 7'h00;
            digit_r       <= 4'h0;
            digit_valid_r <= 1'b0;
            blank_r       <= 1'b1;
            invalid_r     <= 1'b0;
            change_cnt_r  <= 8'd0;
        end else begin
            sync1         <= bus.seg_in;
            sync2         <= sync1;
            cand          <= cand_nxt;
            stab          <= stab_nxt;
            digit_valid_r <= 1'b0;
            if (accept && cand != locked) begin
                if (dec.ok) begin
                    digit_r       <= dec.digit;
                    digit_valid_r <= 1'b1;
                    blank_r       <= 1'b0;
                    locked        <= cand;
                    if (change_cnt_r != 8'hFF) change_cnt_r <= change_cnt_r + 8'd1;
                end else if (cand == 7'h00) begin
                    blank_r <= 1'b1;
                    locked  <= 7'h00;
                end else begin
                    invalid_r <= 1'b1;
                    locked    <= cand;
                end
            end
            if (bus.clr) begin
                change_cnt_r <= 8'd0;
                invalid_r    <= 1'b0;
            end
        end
    end

    assign bus.digit       = digit_r;
    assign bus.digit_valid = digit_valid_r;
    assign bus.blank       = blank_r;
    assign bus.invalid     = invalid_r;
    assign bus.change_cnt  = change_cnt_r;

`ifdef SEG7_CAPTURE_SEQ_CHECK_EN
    localparam logic [4:0] MOD5 = 5'(MODULO);

    logic [3:0] prev_digit;
    logic       armed, seq_err_r;
    logic [4:0] seq_exp;
    logic       take_digit;

    assign take_digit = accept && (cand != locked) && dec.ok;
    assign seq_exp    = ({1'b0, prev_digit} + 5'd1) % MOD5;

    // Each digit accept after the first must follow the previous one mod
    // MODULO; clr disarms so the following accept starts a new sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_digit <= 4'h0;
            armed      <= 1'b0;
            seq_err_r  <= 1'b0;
        end else begin
            if (take_digit) begin
                if (armed && {1'b0, dec.digit} != seq_exp) seq_err_r <= 1'b1;
                prev_digit <= dec.digit;
                armed      <= 1'b1;
            end
            if (bus.clr) begin
                armed     <= 1'b0;
                seq_err_r <= 1'b0;
            end
        end
    end

    assign bus.seq_err = seq_err_r;
`else
    assign bus.seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus randomized pattern holds,
// checked against a run-length reference model with a pulse scoreboard.
module tb_seg7_capture;
    localparam int S = 4;
    localparam int M = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_capture_if bus();

    seg7_capture #(.STABLE_CYCLES(S), .MODULO(M)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vec  = 0;
    int errs = 0;

    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int d;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: what the outputs should be after each edge.
    logic [6:0] m_s1, m_s2, m_held, m_locked, m_w;
    int m_run, m_digit, m_cnt, m_prev, m_d;
    bit m_pulse, m_blank, m_inv, m_seq, m_armed, m_acc;

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a pattern seen two edges late is accepted once it has been seen
    // S+1 times in a row, counted from a change.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 7'h00; m_s2 = 7'h00; m_held = 7'h00; m_locked = 7'h00;
            m_run = 0; m_digit = 0; m_cnt = 0; m_prev = 0;
            m_pulse = 0; m_blank = 1; m_inv = 0; m_seq = 0; m_armed = 0;
            exp_q.delete();
        end else begin
            m_w = m_s2; m_s2 = m_s1; m_s1 = bus.seg_in;
            m_pulse = 0; m_acc = 0;
            if (m_w != m_held) begin
                m_held = m_w;
                m_run = 1;
            end else if (m_run > 0 && m_run <= S) begin
                m_run++;
                if (m_run == S + 1) m_acc = 1;
            end
            m_d = -1;
            if (m_acc && m_w != m_locked) begin
                m_d = decode(m_w);
                if (m_d >= 0) begin
                    m_digit = m_d; m_pulse = 1; m_blank = 0; m_locked = m_w;
                    if (m_cnt < 255) m_cnt++;
`ifdef SEG7_CAPTURE_SEQ_CHECK_EN
                    if (m_armed && m_d != (m_prev + 1) % M) m_seq = 1;
                    m_prev = m_d; m_armed = 1;
`endif
                end else if (m_w == 7'h00) begin
                    m_blank = 1; m_locked = 7'h00;
                end else begin
                    m_inv = 1; m_locked = m_w;
                end
            end
            if (bus.clr) begin
                m_cnt = 0; m_inv = 0; m_seq = 0; m_armed = 0;
            end
            if (m_pulse) exp_q.push_back('{d: m_digit, cnt: m_cnt});
        end
    end

    // Monitor: pop the scoreboard on every pulse, and track status outputs.
    always @(negedge clk) begin
        exp_t e;
        chk("digit_valid", int'(bus.digit_valid), int'(m_pulse));
        if (bus.digit_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_digit", int'(bus.digit), e.d);
                chk("pulse_cnt", int'(bus.change_cnt), e.cnt);
            end
        end
        chk("digit", int'(bus.digit), m_digit);
        chk("blank", int'(bus.blank), int'(m_blank));
        chk("invalid", int'(bus.invalid), int'(m_inv));
        chk("change_cnt", int'(bus.change_cnt), m_cnt);
        chk("seq_err", int'(bus.seq_err), int'(m_seq));
    end

    initial begin
        int r, len;
        logic [6:0] p, last_p;
        bus.seg_in = 7'h00;
        bus.clr    = 1'b0;
        rst_n      = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        chk("rst_digit", int'(bus.digit), 0);
        chk("rst_blank", int'(bus.blank), 1);
        chk("rst_cnt", int'(bus.change_cnt), 0);
        chk("rst_invalid", int'(bus.invalid), 0);

        // First digit: accept on edge S+3 after the pattern appears.
        bus.seg_in = 7'h06;
        cyc(S + 2);
        chk("lat_no_pulse_yet", int'(bus.digit_valid), 0);
        cyc(1);
        chk("lat_pulse", int'(bus.digit_valid), 1);
        cyc(3);
        chk("d1_digit", int'(bus.digit), 1);
        chk("d1_cnt", int'(bus.change_cnt), 1);
        chk("d1_blank", int'(bus.blank), 0);

        // Short glitch is filtered, then a held pattern accepted.
        bus.seg_in = 7'h5B; cyc(3);
        bus.seg_in = 7'h4F; cyc(10);
        chk("glitch_digit", int'(bus.digit), 3);
        chk("glitch_cnt", int'(bus.change_cnt), 2);

        // Undecodable, then clear.
        bus.seg_in = 7'h12; cyc(10);
        chk("inv_flag", int'(bus.invalid), 1);
        chk("inv_digit", int'(bus.digit), 3);
        bus.clr = 1'b1; cyc(1); bus.clr = 1'b0;
        chk("clr_inv", int'(bus.invalid), 0);
        chk("clr_cnt", int'(bus.change_cnt), 0);

        // Counting sequence with wrap, then an out-of-order digit.
        for (int i = 0; i <= M; i++) begin
            bus.seg_in = pat_tab[i % M];
            cyc(10);
        end
        chk("seq_cnt", int'(bus.change_cnt), 8);
        bus.seg_in = pat_tab[2]; cyc(10);
        chk("seq_digit", int'(bus.digit), 2);

        // Reset in the middle of a settle window.
        bus.seg_in = 7'h7F; cyc(4);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        cyc(S + 2);
        chk("rst_mid_pending", int'(bus.digit_valid), 0);
        cyc(1);
        chk("rst_mid_pulse", int'(bus.digit_valid), 1);
        cyc(2);
        chk("rst_mid_digit", int'(bus.digit), 8);
        chk("rst_mid_cnt", int'(bus.change_cnt), 1);

        // clr on the accept edge: update happens, count cleared.
        bus.seg_in = 7'h6F; cyc(S + 2);
        bus.clr = 1'b1; cyc(1); bus.clr = 1'b0;
        chk("clracc_valid", int'(bus.digit_valid), 1);
        chk("clracc_digit", int'(bus.digit), 9);
        chk("clracc_cnt", int'(bus.change_cnt), 0);
        cyc(4);

        // Randomized holds: digits, blanks, junk and bounces back.
        last_p = 7'h6F;
        for (int seg = 0; seg < 500; seg++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      p = pat_tab[$urandom_range(0, 15)];
            else if (r == 7) p = 7'h00;
            else if (r == 8) p = 7'($urandom_range(0, 127));
            else             p = last_p;
            last_p = bus.seg_in;
            bus.seg_in = p;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S + 2) : $urandom_range(S + 3, 12);
            for (int c = 0; c < len; c++) begin
                bus.clr = ($urandom_range(0, 29) == 0);
                cyc(1);
            end
            bus.clr = 1'b0;
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0; cyc($urandom_range(1, 2)); rst_n = 1'b1;
            end
        end
        cyc(12);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
